// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: turns each accepted intensity sample into a WINDOW_STEPS-long spike train,
// using either accumulator carry-out or LFSR Poisson encoding.
module spike_rate_encoder #(
  parameter int          INTENSITY_WIDTH = 8,
  parameter int          WINDOW_STEPS    = 32,
  parameter int          ENCODING        = 0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INTENSITY_WIDTH-1:0]         in_intensity,
  input  logic                               step_en,
  input  logic                               flush,
  output logic                               spike_out,
  output logic                               window_done,
  output logic [$clog2(WINDOW_STEPS+1)-1:0]  spike_count
);
  localparam int W = INTENSITY_WIDTH;
  localparam int CW = $clog2(WINDOW_STEPS + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  logic [0:0]    state_q, state_d;
  logic [W-1:0]  int_q, int_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          spike_q, spike_d;
  logic          done_q, done_d;
  logic [W:0]    sum;
  logic [15:0]   lfsr_nx;
  logic          spike;
  assign sum = {1'b0, acc_q} + {1'b0, int_q};
  assign lfsr_nx = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign spike = (ENCODING == 0) ? sum[W] : (lfsr_nx[W-1:0] < int_q);
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    acc_d   = acc_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    spike_d = 1'b0;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (in_valid && !flush) begin
        int_d   = in_intensity;
        acc_d   = '0;
        step_d  = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
    end else if (flush) begin
      state_d = IDLE;
    end else if (step_en) begin
      acc_d   = sum[W-1:0];
      lfsr_d  = lfsr_nx;
      spike_d = spike;
      cnt_d   = cnt_q + CW'(spike && cnt_q != CW'(WINDOW_STEPS));
      step_d  = step_q + CW'(1);
      // The final step retires the window on the same edge it emits its spike.
      done_d  = step_q == CW'(WINDOW_STEPS - 1);
      state_d = done_d ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      int_q   <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      spike_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      spike_q <= spike_d;
      done_q  <= done_d;
    end
  end
  assign in_ready    = state_q == IDLE;
  assign spike_out   = spike_q;
  assign window_done = done_q;
  assign spike_count = cnt_q;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: drives an accumulator and an LFSR encoder with shared stimulus and
// checks both against a reference model through an expected-result queue.
module tb_spike_rate_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_intensity = '0;
  logic step_en = 1'b0;
  logic flush = 1'b0;
  logic ready0, ready1, spike0, spike1, done0, done1;
  logic [5:0] cnt0, cnt1;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    bit s0;
    bit s1;
    bit done;
    int c0;
    int c1;
  } exp_t;
  exp_t sb[$];
  logic [8:0]  m_sum;
  logic [7:0]  m_acc, m_int;
  logic [15:0] m_lfsr = 16'hACE1;
  int m_step, m_c0, m_c1;
  bit seq1[4096];
  bit seq2[4096];
  always #5 clk = ~clk;
  spike_rate_encoder #(.ENCODING(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready0), .in_intensity(in_intensity),
    .step_en(step_en), .flush(flush), .spike_out(spike0), .window_done(done0), .spike_count(cnt0)
  );
  spike_rate_encoder #(.ENCODING(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready1), .in_intensity(in_intensity),
    .step_en(step_en), .flush(flush), .spike_out(spike1), .window_done(done1), .spike_count(cnt1)
  );
  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_acc = '0;
    m_step = 0;
    m_c0 = 0;
    m_c1 = 0;
    sb.delete();
  endtask
  task automatic accept(input logic [7:0] v);
    in_valid = 1'b1;
    in_intensity = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_int = v; m_acc = '0; m_step = 0; m_c0 = 0; m_c1 = 0;
    n_checks++;
    if (ready0 !== 1'b0 || ready1 !== 1'b0 || cnt0 !== 6'd0 || cnt1 !== 6'd0) begin
      n_fail++;
      $display("FAIL accept: ready=%b/%b count=%0d/%0d, required ready=0/0 count=0/0", ready0, ready1, cnt0, cnt1);
    end
  endtask
  task automatic do_step();
    exp_t e;
    m_sum = {1'b0, m_acc} + {1'b0, m_int};
    m_acc = m_sum[7:0];
    e.s0 = m_sum[8];
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    e.s1 = m_lfsr[7:0] < m_int;
    if (e.s0 && m_c0 < 32) m_c0++;
    if (e.s1 && m_c1 < 32) m_c1++;
    m_step++;
    e.done = m_step == 32;
    e.c0 = m_c0;
    e.c1 = m_c1;
    sb.push_back(e);
    step_en = 1'b1;
    @(posedge clk); #1;
    step_en = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (spike0 !== e.s0 || spike1 !== e.s1 || done0 !== e.done || done1 !== e.done ||
        cnt0 !== 6'(e.c0) || cnt1 !== 6'(e.c1) || ready0 !== e.done || ready1 !== e.done) begin
      n_fail++;
      $display("FAIL step %0d: spike=%b/%b done=%b/%b count=%0d/%0d ready=%b/%b, required spike=%b/%b done=%b count=%0d/%0d ready=%b",
               m_step, spike0, spike1, done0, done1, cnt0, cnt1, ready0, ready1, e.s0, e.s1, e.done, e.c0, e.c1, e.done);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (spike0 !== 1'b0 || spike1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle: spike=%b/%b done=%b/%b, required all 0", spike0, spike1, done0, done1);
      end
    end
  endtask
  task automatic run_window(input logic [7:0] v, input int exp_c0, input string name);
    accept(v);
    for (int i = 0; i < 32; i++) do_step();
    n_checks++;
    if (cnt0 !== 6'(exp_c0) || ready0 !== 1'b1 || done0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: count=%0d ready=%b done=%b, required count=%0d ready=1 done=1", name, cnt0, ready0, done0, exp_c0);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; step_en = 1'b1; in_intensity = 8'd128;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (ready0 !== 1'b1 || spike0 !== 1'b0 || spike1 !== 1'b0 || done0 !== 1'b0 || cnt0 !== 6'd0 || cnt1 !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_hold: ready=%b spike=%b/%b done=%b count=%0d/%0d, required ready=1 others 0",
                 ready0, spike0, spike1, done0, cnt0, cnt1);
      end
    end
    in_valid = 1'b0; step_en = 1'b0; rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b/%b, required 1/1", ready0, ready1);
    end
  endtask
  task automatic test_rates();
    run_window(8'd128, 16, "half_rate");
    run_window(8'd0, 0, "zero_rate");
    run_window(8'd255, 31, "full_rate");
    accept(8'd64);
    for (int i = 0; i < 32; i++) begin
      do_step();
      idle(4);
    end
    n_checks++;
    if (cnt0 !== 6'd8 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL gapped_rate: count=%0d ready=%b, required count=8 ready=1", cnt0, ready0);
    end
  endtask
  task automatic test_back_to_back();
    in_valid = 1'b1; in_intensity = 8'd200;
    @(posedge clk); #1;
    m_int = 8'd200; m_acc = '0; m_step = 0; m_c0 = 0; m_c1 = 0;
    in_intensity = 8'd10;
    for (int i = 0; i < 32; i++) do_step();
    n_checks++;
    if (cnt0 !== 6'd25) begin
      n_fail++;
      $display("FAIL held_intensity: count=%0d, required 25", cnt0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_int = 8'd10; m_acc = '0; m_step = 0; m_c0 = 0; m_c1 = 0;
    n_checks++;
    if (ready0 !== 1'b0 || cnt0 !== 6'd0) begin
      n_fail++;
      $display("FAIL second_accept: ready=%b count=%0d, required ready=0 count=0", ready0, cnt0);
    end
    for (int i = 0; i < 32; i++) do_step();
    n_checks++;
    if (cnt0 !== 6'd1) begin
      n_fail++;
      $display("FAIL second_window: count=%0d, required 1", cnt0);
    end
  endtask
  task automatic test_flush_and_reset();
    accept(8'd128);
    for (int i = 0; i < 9; i++) do_step();
    step_en = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    step_en = 1'b0; flush = 1'b0;
    n_checks++;
    if (spike0 !== 1'b0 || spike1 !== 1'b0 || done0 !== 1'b0 || ready0 !== 1'b1 || cnt0 !== 6'd4 || cnt1 !== 6'(m_c1)) begin
      n_fail++;
      $display("FAIL flush: spike=%b/%b done=%b ready=%b count=%0d/%0d, required spike=0 done=0 ready=1 count=4/%0d",
               spike0, spike1, done0, ready0, cnt0, cnt1, m_c1);
    end
    idle(2);
    accept(8'd255);
    for (int i = 0; i < 19; i++) do_step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (spike0 !== 1'b0 || spike1 !== 1'b0 || done0 !== 1'b0 || cnt0 !== 6'd0 || cnt1 !== 6'd0 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: spike=%b/%b done=%b count=%0d/%0d ready=%b, required 0 0 0 0 1",
               spike0, spike1, done0, cnt0, cnt1, ready0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    idle(1);
  endtask
  task automatic long_run(input bit second);
    int total;
    total = 0;
    for (int w = 0; w < 128; w++) begin
      accept(8'd64);
      for (int i = 0; i < 32; i++) begin
        do_step();
        total += int'(spike1);
        if (second) seq2[w*32+i] = spike1;
        else seq1[w*32+i] = spike1;
      end
    end
    n_checks++;
    if (total < 924 || total > 1124) begin
      n_fail++;
      $display("FAIL poisson_rate: spikes=%0d, required 924..1124", total);
    end
  endtask
  task automatic test_poisson();
    int diffs;
    long_run(1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    long_run(1'b1);
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (seq1[i] != seq2[i]) diffs++;
    n_checks++;
    if (diffs != 0) begin
      n_fail++;
      $display("FAIL poisson_repeat: differing steps=%0d, required 0", diffs);
    end
  endtask
  initial begin
    test_reset();
    test_rates();
    test_back_to_back();
    test_flush_and_reset();
    test_poisson();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
